// File: rtl/cv32e40p_apu_resp.sv
// Shared-APU responder: in-order request queue feeding a multi-cycle ADD/NOP/MAC/DIV engine.
// Optional macro APU_RESP_BYPASS_EN lets ADD/NOP skip the empty queue when the engine is idle.
module cv32e40p_apu_resp #(
    parameter int unsigned DEPTH            = 2,
    parameter int unsigned APU_NARGS_CPU    = 3,
    parameter int unsigned APU_WOP_CPU      = 6,
    parameter int unsigned APU_NUSFLAGS_CPU = 5,
    parameter int unsigned MUL_LAT          = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                apu_req_i,
    output logic                                apu_gnt_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]              apu_op_i,
    output logic                                apu_rvalid_o,
    output logic [31:0]                         apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_o,
    output logic                                busy_o,
    output logic [$clog2(DEPTH):0]              queue_count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpMac = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    // Busy-cycle counts: the pop cycle is the first of LAT cycles.
    localparam logic [5:0] MacBusy = 6'(MUL_LAT - 1);
    localparam logic [5:0] DivBusy = 6'd31;

    function automatic logic [31:0] f_lat1(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        return (op == OpAdd) ? a + b : 32'd0;
    endfunction

    // Request queue
    logic [31:0]   r_q_a  [DEPTH];
    logic [31:0]   r_q_b  [DEPTH];
    logic [31:0]   r_q_c  [DEPTH];
    logic [1:0]    r_q_op [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Engine
    logic        r_state;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_opc;
    logic [31:0] r_rem;
    logic        r_dz;

    // Response
    logic        r_rvalid;
    logic [31:0] r_result;
    logic        r_flag_dz;

    logic        w_gnt;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_op_in;
    logic [31:0] w_head_a;
    logic [31:0] w_head_b;
    logic [31:0] w_head_c;
    logic [1:0]  w_head_op;
    logic        w_last_busy;

    logic [31:0] w_div_rem_in;
    logic [31:0] w_div_dvd_in;
    logic [31:0] w_div_dsr;
    logic [32:0] w_div_trial;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [32:0] w_div_rem33;
    logic [31:0] w_div_rem_nx;
    logic [31:0] w_div_dvd_nx;
    logic [31:0] w_mac;

    logic        w_done;
    logic [31:0] w_done_res;
    logic        w_done_dz;
    logic        w_unused_bits;

    assign w_op_in   = apu_op_i[1:0];
    assign w_head_a  = r_q_a[r_rd_ptr];
    assign w_head_b  = r_q_b[r_rd_ptr];
    assign w_head_c  = r_q_c[r_rd_ptr];
    assign w_head_op = r_q_op[r_rd_ptr];

    // Grant uses the pre-pop count, so a full queue never accepts in its pop cycle.
    assign w_gnt = apu_req_i & (r_count < DepthC);

`ifdef APU_RESP_BYPASS_EN
    assign w_bypass = w_gnt & ~w_op_in[1] & (r_count == '0) & (r_state == StIdle);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_gnt & ~w_bypass;
    assign w_pop       = (r_state == StIdle) & (r_count != '0);
    assign w_last_busy = (r_state == StBusy) & (r_cnt == 6'd1);

    // One restoring-division step; the dividend register collects quotient bits as it shifts.
    assign w_div_rem_in = (r_state == StIdle) ? 32'd0 : r_rem;
    assign w_div_dvd_in = (r_state == StIdle) ? w_head_a : r_opa;
    assign w_div_dsr    = (r_state == StIdle) ? w_head_b : r_opb;
    assign w_div_trial  = {w_div_rem_in, w_div_dvd_in[31]};
    assign w_div_diff   = w_div_trial - {1'b0, w_div_dsr};
    assign w_div_ge     = (w_div_trial >= {1'b0, w_div_dsr});
    assign w_div_rem33  = w_div_ge ? w_div_diff : w_div_trial;
    assign w_div_rem_nx = w_div_rem33[31:0];
    assign w_div_dvd_nx = {w_div_dvd_in[30:0], w_div_ge};

    assign w_mac = r_opa * r_opb + r_opc;

    assign w_unused_bits = ^{apu_op_i[APU_WOP_CPU-1:2], w_div_rem33[32]};

    always_comb begin
        w_done     = 1'b0;
        w_done_res = 32'd0;
        w_done_dz  = 1'b0;
        if (w_bypass) begin
            w_done     = 1'b1;
            w_done_res = f_lat1(w_op_in, apu_operands_i[0], apu_operands_i[1]);
        end else if (w_pop && !w_head_op[1]) begin
            w_done     = 1'b1;
            w_done_res = f_lat1(w_head_op, w_head_a, w_head_b);
        end else if (w_last_busy) begin
            w_done = 1'b1;
            if (r_op == OpMac) begin
                w_done_res = w_mac;
            end else begin
                w_done_res = r_dz ? 32'hFFFF_FFFF : w_div_dvd_nx;
                w_done_dz  = r_dz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_a[r_wr_ptr]  <= apu_operands_i[0];
            r_q_b[r_wr_ptr]  <= apu_operands_i[1];
            r_q_c[r_wr_ptr]  <= apu_operands_i[2];
            r_q_op[r_wr_ptr] <= w_op_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_opc   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else if (r_state == StIdle) begin
            if (w_pop && w_head_op[1]) begin
                r_state <= StBusy;
                r_op    <= w_head_op;
                r_opb   <= w_head_b;
                if (w_head_op == OpDiv) begin
                    r_opa <= w_div_dvd_nx;
                    r_rem <= w_div_rem_nx;
                    r_dz  <= (w_head_b == 32'd0);
                    r_cnt <= DivBusy;
                end else begin
                    r_opa <= w_head_a;
                    r_opc <= w_head_c;
                    r_dz  <= 1'b0;
                    r_cnt <= MacBusy;
                end
            end
        end else begin
            if (r_op == OpDiv) begin
                r_opa <= w_div_dvd_nx;
                r_rem <= w_div_rem_nx;
            end
            if (w_last_busy) begin
                r_state <= StIdle;
            end else begin
                r_cnt <= r_cnt - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid  <= 1'b0;
            r_result  <= '0;
            r_flag_dz <= 1'b0;
        end else begin
            r_rvalid <= w_done;
            if (w_done) begin
                r_result  <= w_done_res;
                r_flag_dz <= w_done_dz;
            end
        end
    end

    always_comb begin
        apu_flags_o    = '0;
        apu_flags_o[3] = r_flag_dz;
    end

    assign apu_gnt_o     = w_gnt;
    assign apu_rvalid_o  = r_rvalid;
    assign apu_result_o  = r_result;
    assign queue_count_o = r_count;
    assign busy_o        = (r_count != '0) | (r_state == StBusy) | r_rvalid;

endmodule

// File: tb/tb_cv32e40p_apu_resp.sv
// Scoreboard bench for cv32e40p_apu_resp: directed latency scenarios plus random traffic.
module tb_cv32e40p_apu_resp;

    localparam int DEPTH = 2;
    localparam int NARGS = 3;
    localparam int WOP   = 6;
    localparam int NFL   = 5;
    localparam int MULL  = 3;
`ifdef APU_RESP_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   apu_req_i;
    logic                   apu_gnt_o;
    logic [NARGS-1:0][31:0] apu_operands_i;
    logic [WOP-1:0]         apu_op_i;
    logic                   apu_rvalid_o;
    logic [31:0]            apu_result_o;
    logic [NFL-1:0]         apu_flags_o;
    logic                   busy_o;
    logic [$clog2(DEPTH):0] queue_count_o;

    cv32e40p_apu_resp #(
        .DEPTH            (DEPTH),
        .APU_NARGS_CPU    (NARGS),
        .APU_WOP_CPU      (WOP),
        .APU_NUSFLAGS_CPU (NFL),
        .MUL_LAT          (MULL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .apu_req_i      (apu_req_i),
        .apu_gnt_o      (apu_gnt_o),
        .apu_operands_i (apu_operands_i),
        .apu_op_i       (apu_op_i),
        .apu_rvalid_o   (apu_rvalid_o),
        .apu_result_o   (apu_result_o),
        .apu_flags_o    (apu_flags_o),
        .busy_o         (busy_o),
        .queue_count_o  (queue_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          ecyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   next_id = 0;

    // Reference behaviour straight from the op definitions.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.flg = 5'b0;
        e.ecyc = -1;
        e.id = 0;
        case (op)
            2'b00: e.res = a + b;
            2'b01: e.res = 32'd0;
            2'b10: e.res = a * b + c;
            default: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.flg = 5'b01000;
                end else begin
                    e.res = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pops one expectation.
    always @(negedge clk) begin
        if (rst_n && apu_rvalid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rvalid: got result %h with no outstanding request",
                         apu_result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (apu_result_o !== e.res || apu_flags_o !== e.flg) begin
                    bad++;
                    $display("FAIL resp#%0d: got res=%h flags=%b want res=%h flags=%b",
                             e.id, apu_result_o, apu_flags_o, e.res, e.flg);
                end
                if (e.ecyc >= 0) begin
                    total++;
                    if (cyc != e.ecyc) begin
                        bad++;
                        $display("FAIL latency#%0d: got rvalid at cycle %0d want %0d",
                                 e.id, cyc, e.ecyc);
                    end
                end
            end
        end
    end

    // Called at a negedge; holds req until granted, returns at the following negedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int exp_off, output int g_cyc);
        int   w;
        exp_t e;
        apu_req_i         = 1'b1;
        apu_op_i          = {4'($urandom_range(0, 15)), op};
        apu_operands_i[0] = a;
        apu_operands_i[1] = b;
        apu_operands_i[2] = c;
        g_cyc = -1;
        w = 0;
        #1;
        while (!apu_gnt_o && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (apu_gnt_o) begin
            e = model(op, a, b, c);
            e.ecyc = (exp_off >= 0) ? cyc + exp_off : -1;
            e.id = next_id;
            next_id++;
            sb.push_back(e);
            g_cyc = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no gnt after %0d cycles want gnt", w);
        end
        @(negedge clk);
        apu_req_i = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding want 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    int g0, g1, g2, g3;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        rst_n          = 1'b0;
        apu_req_i      = 1'b0;
        apu_op_i       = '0;
        apu_operands_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {31'd0, apu_gnt_o}, 32'd0);
        chk("rst_rvalid", {31'd0, apu_rvalid_o}, 32'd0);
        chk("rst_result", apu_result_o, 32'd0);
        chk("rst_flags", {27'd0, apu_flags_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_count", {30'd0, queue_count_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD from idle
        issue(2'b00, 32'd5, 32'd7, 32'd0, 2 - BYP, g0);
        wait_to(g0 + 2 - BYP);
        chk("add_busy_at_rvalid", {31'd0, busy_o}, 32'd1);
        wait_to(g0 + 3 - BYP);
        chk("add_busy_after", {31'd0, busy_o}, 32'd0);
        chk("add_count_after", {30'd0, queue_count_o}, 32'd0);
        drain();

        // Back-to-back ADDs, one per cycle
        issue(2'b00, 32'd1, 32'd1, 32'd0, 2 - BYP, g0);
        issue(2'b00, 32'd2, 32'd2, 32'd0, 2 - BYP, g1);
        issue(2'b00, 32'd3, 32'd3, 32'd0, 2 - BYP, g2);
        issue(2'b00, 32'd4, 32'd4, 32'd0, 2 - BYP, g3);
        chk("b2b_gnt1", g1, g0 + 1);
        chk("b2b_gnt2", g2, g0 + 2);
        chk("b2b_gnt3", g3, g0 + 3);
        drain();

        // MAC then ADD queued behind it
        issue(2'b10, 32'd3, 32'd4, 32'd10, MULL + 1, g0);
        issue(2'b00, 32'd1, 32'd1, 32'd0, MULL + 1, g1);
        drain();

        // DIV, then divide by zero
        issue(2'b11, 32'd100, 32'd7, 32'd0, 33, g0);
        issue(2'b11, 32'd9, 32'd0, 32'd0, 64, g1);
        drain();

        // Full queue behind a DIV
        issue(2'b11, 32'd50, 32'd5, 32'd0, 33, g0);
        issue(2'b00, 32'd10, 32'd20, 32'd0, 33, g1);
        issue(2'b00, 32'd30, 32'd40, 32'd0, 33, g2);
        issue(2'b00, 32'd7, 32'd8, 32'd0, 2, g3);
        chk("full_held_gnt", g3, g0 + 34);
        drain();

        // Reset mid-DIV with one request queued
        issue(2'b11, 32'd1000, 32'd3, 32'd0, -1, g0);
        issue(2'b00, 32'd1, 32'd2, 32'd0, -1, g1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, apu_rvalid_o}, 32'd0);
        chk("mid_rst_result", apu_result_o, 32'd0);
        chk("mid_rst_flags", {27'd0, apu_flags_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_count", {30'd0, queue_count_o}, 32'd0);
        chk("mid_rst_gnt", {31'd0, apu_gnt_o}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd2, 32'd3, 32'd0, 2 - BYP, g0);
        drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 100));
            else rb = $urandom;
            issue(rop, ra, rb, $urandom, -1, g0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
